// File: rtl/rregs_sr.sv
// rregs_sr: generic rising-edge pipeline register, DEPTH stages of WIDTH bits.
// Synchronous active-high reset loads RST_VAL into every stage.
// Optional build macro RREGS_SR_CLKEN_EN adds a load enable (en) that
// freezes the whole chain when low.
module rregs_sr #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                   eph1,
  input  logic                   reset,
`ifdef RREGS_SR_CLKEN_EN
  input  logic                   en,
`endif
  input  logic [WIDTH-1:0]       d,
  output logic [WIDTH-1:0]       q,
  output logic [DEPTH*WIDTH-1:0] taps
);

  if (WIDTH < 1 || WIDTH > 1024) begin : g_bad_width
    $error("rregs_sr: WIDTH=%0d outside 1..1024", WIDTH);
  end
  if (DEPTH < 1 || DEPTH > 64) begin : g_bad_depth
    $error("rregs_sr: DEPTH=%0d outside 1..64", DEPTH);
  end

  logic [WIDTH-1:0] stage [DEPTH];
  logic             shift_en;

`ifdef RREGS_SR_CLKEN_EN
  assign shift_en = en;
`else
  assign shift_en = 1'b1;
`endif

  // Stage 0 captures d; reset wins over enable and data.
  always_ff @(posedge eph1) begin
    if (reset) begin
      stage[0] <= RST_VAL;
    end else if (shift_en) begin
      stage[0] <= d;
    end
  end

  for (genvar i = 1; i < DEPTH; i++) begin : g_stage
    // Stage i captures stage i-1 under the same reset/enable as stage 0.
    always_ff @(posedge eph1) begin
      if (reset) begin
        stage[i] <= RST_VAL;
      end else if (shift_en) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_taps
    assign taps[i*WIDTH +: WIDTH] = stage[i];
  end

  assign q = stage[DEPTH-1];

endmodule

// File: tb/tb_rregs_sr.sv
// tb_rregs_sr: self-checking bench for rregs_sr. Five instances with different
// WIDTH/DEPTH/RST_VAL share one clock; a log-based reference model predicts
// every tap of every instance after every edge.
module tb_rregs_sr;

  localparam int NM = 5;
  localparam int LOGN = 4096;

  int          wd  [NM] = '{1, 8, 8, 128, 8};
  int          dp  [NM] = '{1, 12, 4, 1, 3};
  logic [127:0] rv [NM] = '{128'h0, 128'hA5, 128'h3C,
                            {4{32'hDEADBEEF}}, 128'h5A};

  logic         eph1 = 1'b0;
  logic         rs [NM];
  logic         en [NM];
  logic [127:0] dd [NM];

  logic [0:0]   q1,   t1;
  logic [7:0]   q12;
  logic [95:0]  t12;
  logic [7:0]   q4;
  logic [31:0]  t4;
  logic [127:0] q128, t128;
  logic [7:0]   q3;
  logic [23:0]  t3;

  int tests = 0;
  int fails = 0;

  // Reference model: log of every accepted d per instance; base marks the
  // log position at the most recent reset.
  logic [127:0] log_d [NM][LOGN];
  int           n_acc [NM];
  int           base  [NM];

  always #5 eph1 = ~eph1;

  rregs_sr #(.WIDTH(1), .DEPTH(1), .RST_VAL(1'b0)) u_w1 (
    .eph1(eph1), .reset(rs[0]),
`ifdef RREGS_SR_CLKEN_EN
    .en(en[0]),
`endif
    .d(dd[0][0:0]), .q(q1), .taps(t1));

  rregs_sr #(.WIDTH(8), .DEPTH(12), .RST_VAL(8'hA5)) u_d12 (
    .eph1(eph1), .reset(rs[1]),
`ifdef RREGS_SR_CLKEN_EN
    .en(en[1]),
`endif
    .d(dd[1][7:0]), .q(q12), .taps(t12));

  rregs_sr #(.WIDTH(8), .DEPTH(4), .RST_VAL(8'h3C)) u_d4 (
    .eph1(eph1), .reset(rs[2]),
`ifdef RREGS_SR_CLKEN_EN
    .en(en[2]),
`endif
    .d(dd[2][7:0]), .q(q4), .taps(t4));

  rregs_sr #(.WIDTH(128), .DEPTH(1), .RST_VAL({4{32'hDEADBEEF}})) u_w128 (
    .eph1(eph1), .reset(rs[3]),
`ifdef RREGS_SR_CLKEN_EN
    .en(en[3]),
`endif
    .d(dd[3]), .q(q128), .taps(t128));

  rregs_sr #(.WIDTH(8), .DEPTH(3), .RST_VAL(8'h5A)) u_d3 (
    .eph1(eph1), .reset(rs[4]),
`ifdef RREGS_SR_CLKEN_EN
    .en(en[4]),
`endif
    .d(dd[4][7:0]), .q(q3), .taps(t3));

  function automatic logic [127:0] msk(int m);
    return (wd[m] >= 128) ? '1 : ((128'd1 << wd[m]) - 128'd1);
  endfunction

  function automatic logic [127:0] get_tap(int m, int i);
    case (m)
      0:       return 128'(t1[0]);
      1:       return 128'(t12[i*8 +: 8]);
      2:       return 128'(t4[i*8 +: 8]);
      3:       return t128;
      default: return 128'(t3[i*8 +: 8]);
    endcase
  endfunction

  function automatic logic [127:0] get_q(int m);
    case (m)
      0:       return 128'(q1);
      1:       return 128'(q12);
      2:       return 128'(q4);
      3:       return q128;
      default: return 128'(q3);
    endcase
  endfunction

  // Tap i holds the value accepted i shifts ago, if that happened since reset.
  function automatic logic [127:0] exp_tap(int m, int i);
    int idx;
    idx = n_acc[m] - 1 - i;
    return (idx >= base[m]) ? log_d[m][idx] : (rv[m] & msk(m));
  endfunction

  task automatic check(string name, logic [127:0] got, logic [127:0] expv);
    tests++;
    if (got !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, expv);
    end
  endtask

  function automatic logic en_eff(int m);
`ifdef RREGS_SR_CLKEN_EN
    return en[m];
`else
    return 1'b1;
`endif
  endfunction

  // One clock edge: update the model from the applied inputs, then compare
  // every tap and q of every instance just after the edge.
  task automatic step();
    @(posedge eph1);
    for (int m = 0; m < NM; m++) begin
      if (rs[m]) begin
        base[m] = n_acc[m];
      end else if (en_eff(m)) begin
        if (n_acc[m] >= LOGN) $fatal(1, "FAIL model log overflow");
        log_d[m][n_acc[m]] = dd[m] & msk(m);
        n_acc[m]++;
      end
    end
    #1;
    for (int m = 0; m < NM; m++) begin
      for (int i = 0; i < dp[m]; i++)
        check($sformatf("model_m%0d_tap%0d", m, i), get_tap(m, i), exp_tap(m, i));
      check($sformatf("model_m%0d_q", m), get_q(m), exp_tap(m, dp[m]-1));
    end
  endtask

  typedef struct {
    logic       rst;
    logic       din;
    logic [0:0] exp_q;
  } vec_t;

  vec_t vt [6];

  initial begin
    for (int m = 0; m < NM; m++) begin
      rs[m] = 1'b1; en[m] = 1'b1; dd[m] = '0; n_acc[m] = 0; base[m] = 0;
    end
    @(negedge eph1);
    step();
    step();
    for (int m = 0; m < NM; m++) begin
      check($sformatf("reset_m%0d_q", m), get_q(m), rv[m] & msk(m));
      rs[m] = 1'b0;
    end

    // WIDTH=1, DEPTH=1 flop table
    vt[0] = '{1'b1, 1'b1, 1'b0};
    vt[1] = '{1'b1, 1'b0, 1'b0};
    vt[2] = '{1'b0, 1'b1, 1'b1};
    vt[3] = '{1'b0, 1'b0, 1'b0};
    vt[4] = '{1'b0, 1'b1, 1'b1};
    vt[5] = '{1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 6; k++) begin
      rs[0] = vt[k].rst;
      dd[0] = 128'(vt[k].din);
      step();
      check($sformatf("tbl_w1_row%0d", k), 128'(q1), 128'(vt[k].exp_q));
    end
    rs[0] = 1'b0;

    // DEPTH=12 latency: q reads A5 for 11 edges, then 1,2,3...
    rs[1] = 1'b1; step(); rs[1] = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      dd[1] = 128'(k);
      step();
      check($sformatf("d12_q_k%0d", k), 128'(q12), (k >= 12) ? 128'(k - 11) : 128'hA5);
      check($sformatf("d12_tap0_k%0d", k), 128'(t12[7:0]), 128'(k));
    end

    // DEPTH=4 mid-stream reset flush
    rs[2] = 1'b1; step(); rs[2] = 1'b0;
    dd[2] = 128'h11; step();
    dd[2] = 128'h22; step();
    dd[2] = 128'h33; step();
    dd[2] = 128'h44; step();
    check("d4_full", 128'(t4), 128'h11223344);
    rs[2] = 1'b1; dd[2] = 128'h99; step();
    check("d4_flushed", 128'(t4), 128'h3C3C3C3C);
    rs[2] = 1'b0; dd[2] = 128'h77; step();
    dd[2] = 128'h00;
    for (int k = 2; k <= 4; k++) begin
      check($sformatf("d4_lat_e%0d", k - 1), 128'(q4), 128'h3C);
      step();
    end
    check("d4_lat_e4", 128'(q4), 128'h77);

    // 128-bit bit-exact transfer
    dd[3] = 128'hAB7F34AFDD7382220E089AFB3D909866;
    step();
    check("w128_q", q128, 128'hAB7F34AFDD7382220E089AFB3D909866);

`ifdef RREGS_SR_CLKEN_EN
    // Clock-enable freeze, reset with en=0, resume
    rs[4] = 1'b1; step(); rs[4] = 1'b0;
    dd[4] = 128'hA1; step();
    dd[4] = 128'hB2; step();
    dd[4] = 128'hC3; step();
    en[4] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      dd[4] = 128'($urandom_range(0, 255));
      step();
      check($sformatf("en0_hold_%0d", k), 128'(t3), 128'hA1B2C3);
    end
    rs[4] = 1'b1; step();
    check("en0_reset", 128'(t3), 128'h5A5A5A);
    rs[4] = 1'b0; en[4] = 1'b1; dd[4] = 128'h10; step();
    check("en1_resume", 128'(t3), 128'h5A5A10);
`endif

    // Randomized traffic on all instances
    for (int k = 0; k < 500; k++) begin
      for (int m = 0; m < NM; m++) begin
        rs[m] = ($urandom_range(0, 19) == 0);
        en[m] = ($urandom_range(0, 3) != 0);
        dd[m] = {$urandom, $urandom, $urandom, $urandom} & msk(m);
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
